// File: rtl/i2c_frame_tx_arbiter.sv
// rtl/i2c_frame_tx_arbiter.sv - round-robin arbiter feeding one 11-bit serial frame line
// Frame on SDA_OUT, MSB first: start(0), data[7:0], parity, stop(1); idle gap between frames.
module i2c_frame_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BIT_DIV    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int PARITY_ODD = 0
) (
    input  logic                 SYNCED_CLK,
    input  logic                 RST,
    input  logic [NUM_REQ-1:0]   REQ,
    input  logic [NUM_REQ*8-1:0] DATA_IN,
    output logic [NUM_REQ-1:0]   GNT,
    output logic [2:0]           OWNER,
    output logic                 BUSY,
    output logic                 SDA_OUT,
    output logic                 FRAME_DONE
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [15:0] DIV_LAST = 16'(BIT_DIV - 1);
    localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
    localparam logic        PAR_INV  = (PARITY_ODD != 0);

    logic [1:0]         state;
    logic [10:0]        shreg;
    logic [15:0]        div_cnt;
    logic [3:0]         bit_cnt;
    logic [15:0]        gap_cnt;
    logic [2:0]         rr_ptr;

    logic [2:0]         win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [7:0]         win_byte;
    logic [2:0]         win_next_ptr;
    logic               win_parity;

    // Winner is the set request at the smallest rotation distance from rr_ptr.
    always_comb begin
        int best_d;
        int d;
        win_idx      = 3'd0;
        win_onehot   = '0;
        win_byte     = 8'd0;
        win_next_ptr = 3'd0;
        best_d       = NUM_REQ;
        d            = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            d = (k + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
            if (REQ[k] && (d < best_d)) begin
                best_d        = d;
                win_idx       = 3'(k);
                win_onehot    = '0;
                win_onehot[k] = 1'b1;
                win_byte      = DATA_IN[8*k +: 8];
                win_next_ptr  = (k == NUM_REQ - 1) ? 3'd0 : 3'(k + 1);
            end
        end
    end

    assign win_parity = (^win_byte) ^ PAR_INV;

    // The line is the MSB of the shift register; an all-ones register is the idle level.
    assign SDA_OUT = shreg[10];

    always_ff @(posedge SYNCED_CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            shreg      <= '1;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            rr_ptr     <= '0;
            GNT        <= '0;
            OWNER      <= '0;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            GNT        <= '0;
            FRAME_DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|REQ) begin
                        GNT     <= win_onehot;
                        OWNER   <= win_idx;
                        shreg   <= {1'b0, win_byte, win_parity, 1'b1};
                        BUSY    <= 1'b1;
                        rr_ptr  <= win_next_ptr;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (bit_cnt == 4'd10) begin
                            FRAME_DONE <= 1'b1;
                            shreg      <= '1;
                            gap_cnt    <= '0;
                            if (GAP_CYCLES == 0) begin
                                BUSY  <= 1'b0;
                                state <= ST_IDLE;
                            end else begin
                                state <= ST_GAP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            shreg   <= {shreg[9:0], 1'b1};
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    shreg <= '1;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_frame_tx_arbiter.sv
// tb/tb_i2c_frame_tx_arbiter.sv - bench for i2c_frame_tx_arbiter against a rotation/frame reference model
module tb_i2c_frame_tx_arbiter;

    localparam int NR = 4;
    localparam int BD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req_o;
    logic [31:0] din, din_o;
    logic [3:0]  gnt, gnt_o;
    logic [2:0]  owner, owner_o;
    logic        busy, busy_o, sda, sda_o, fd, fd_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int m_ptr = 0;
    int g_cyc = 0;
    int g_list[5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_frame_tx_arbiter #(.NUM_REQ(4), .BIT_DIV(4), .GAP_CYCLES(2), .PARITY_ODD(0)) u_dut (
        .SYNCED_CLK(clk), .RST(rst), .REQ(req), .DATA_IN(din),
        .GNT(gnt), .OWNER(owner), .BUSY(busy), .SDA_OUT(sda), .FRAME_DONE(fd)
    );

    i2c_frame_tx_arbiter #(.NUM_REQ(4), .BIT_DIV(4), .GAP_CYCLES(2), .PARITY_ODD(1)) u_odd (
        .SYNCED_CLK(clk), .RST(rst), .REQ(req_o), .DATA_IN(din_o),
        .GNT(gnt_o), .OWNER(owner_o), .BUSY(busy_o), .SDA_OUT(sda_o), .FRAME_DONE(fd_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] model_frame(input logic [7:0] b, input bit odd);
        logic p;
        p = odd ? ~(^b) : (^b);
        return {1'b0, b, p, 1'b1};
    endfunction

    // Line level per cycle: each frame bit repeated BD times, MSB first.
    function automatic logic [43:0] expand(input logic [10:0] f);
        logic [43:0] r;
        for (int c = 0; c < 44; c++) r[43-c] = f[10 - c/BD];
        return r;
    endfunction

    function automatic int model_winner(input logic [3:0] r);
        for (int d = 0; d < NR; d++)
            if (r[(m_ptr + d) % NR]) return (m_ptr + d) % NR;
        return -1;
    endfunction

    // Called at a negedge while the DUT is idle; returns at the negedge of the idle cycle after the gap.
    task automatic run_frame(input string tag, input logic [3:0] r, input logic [31:0] d,
                             input bit hold, input int poke_at, input logic [3:0] poke_req,
                             input int rst_at);
        int w;
        logic [3:0]  eg;
        logic [43:0] cap, exp_bits;
        int fd_early, gnt_extra, busy_low;
        req = r;
        din = d;
        w = model_winner(r);
        eg = 4'b0001 << w;
        exp_bits = expand(model_frame(d[8*w +: 8], 1'b0));
        @(negedge clk);
        g_cyc = cyc;
        chk({tag, ".gnt"}, gnt, eg);
        chk({tag, ".owner"}, owner, w);
        chk({tag, ".busy0"}, busy, 1);
        m_ptr = (w + 1) % NR;
        if (!hold) req = '0;
        din = $urandom;
        cap = '0;
        cap[43] = sda;
        fd_early = 0;
        gnt_extra = 0;
        busy_low = 0;
        for (int c = 1; c <= 46; c++) begin
            @(negedge clk);
            if (rst_at >= 0 && c == rst_at + 1) begin
                chk({tag, ".rst_sda"}, sda, 1);
                chk({tag, ".rst_busy"}, busy, 0);
                chk({tag, ".rst_fd"}, fd, 0);
                chk({tag, ".rst_gnt"}, gnt, 0);
                rst = 1'b0;
                m_ptr = 0;
                return;
            end
            if (c < 44) begin
                cap[43-c] = sda;
                if (fd) fd_early++;
            end
            if (gnt !== 4'b0) gnt_extra++;
            if (c < 46 && !busy) busy_low++;
            if (c == 44) begin
                chk({tag, ".fd"}, fd, 1);
                chk({tag, ".stop_idle"}, sda, 1);
            end
            if (c == 45) chk({tag, ".fd_pulse"}, fd, 0);
            if (c == 46) begin
                chk({tag, ".busy_end"}, busy, 0);
                chk({tag, ".idle_sda"}, sda, 1);
            end
            if (c == rst_at) rst = 1'b1;
            if (c == poke_at) req = poke_req;
            else if (poke_at >= 0 && c == poke_at + 1) req = '0;
        end
        chk({tag, ".bits"}, cap, exp_bits);
        chk({tag, ".fd_early"}, fd_early, 0);
        chk({tag, ".gnt_extra"}, gnt_extra, 0);
        chk({tag, ".busy_low"}, busy_low, 0);
    endtask

    task automatic run_odd(input string tag, input logic [7:0] b);
        logic [43:0] cap;
        req_o = 4'b0001;
        din_o = {24'h0, b};
        @(negedge clk);
        chk({tag, ".gnt"}, gnt_o, 4'b0001);
        chk({tag, ".owner"}, owner_o, 0);
        chk({tag, ".busy"}, busy_o, 1);
        req_o = '0;
        cap = '0;
        cap[43] = sda_o;
        for (int c = 1; c <= 46; c++) begin
            @(negedge clk);
            if (c < 44) cap[43-c] = sda_o;
            if (c == 44) chk({tag, ".fd"}, fd_o, 1);
        end
        chk({tag, ".bits"}, cap, expand(model_frame(b, 1'b1)));
    endtask

    initial begin
        int idle_gnt, idle_low;
        rst = 1'b1;
        req = 4'b1111;
        din = $urandom;
        req_o = '0;
        din_o = '0;
        repeat (3) @(negedge clk);
        chk("reset.gnt", gnt, 0);
        chk("reset.owner", owner, 0);
        chk("reset.busy", busy, 0);
        chk("reset.sda", sda, 1);
        chk("reset.fd", fd, 0);
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        chk("idle.sda", sda, 1);
        chk("idle.busy", busy, 0);

        run_frame("t1", 4'b0001, 32'h000000A5, 1'b0, -1, 4'b0, -1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < 5; i++) begin
            run_frame("t2", 4'b1111, 32'h04030201, (i < 4), -1, 4'b0, -1);
            g_list[i] = g_cyc;
        end
        for (int i = 1; i < 5; i++) chk("t2.spacing", g_list[i] - g_list[i-1], 47);

        run_frame("t3a", 4'b1000, $urandom, 1'b0, -1, 4'b0, -1);
        run_frame("t3b", 4'b1001, $urandom, 1'b0, -1, 4'b0, -1);

        run_odd("t4ff", 8'hFF);
        chk("t4.frame_ff", model_frame(8'hFF, 1'b1), 11'b01111111111);
        run_odd("t4rnd", 8'($urandom));

        run_frame("t6", 4'b0100, $urandom, 1'b0, 20, 4'b0010, -1);
        idle_gnt = 0;
        idle_low = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (gnt !== 4'b0) idle_gnt++;
            if (sda !== 1'b1) idle_low++;
        end
        chk("t6.no_grant", idle_gnt, 0);
        chk("t6.line_high", idle_low, 0);

        run_frame("t5", 4'b1111, $urandom, 1'b1, -1, 4'b0, 10);
        run_frame("t5b", 4'b1111, $urandom, 1'b0, -1, 4'b0, -1);

        for (int i = 0; i < 12; i++)
            run_frame("rnd", 4'($urandom_range(1, 15)), $urandom, (i < 11) && ($urandom_range(0, 1) == 1),
                      -1, 4'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
